// File: rtl/irq_arbiter.sv
// irq_arbiter: sticky pending latch, software mask and fixed-priority selection
// of one IRQ source (lowest index wins), presented to CP0 as int_req/int_id and
// held in service until eret. Bus-visible MASK/PEND/STATUS registers.
module irq_arbiter #(
    parameter int NUM_SRC = 6,
    parameter int ID_W    = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               WE,
    input  logic [31:0]        ADD_I,
    input  logic [31:0]        DAT_I,
    output logic [31:0]        DAT_O,
    input  logic [NUM_SRC-1:0] irq_in,
    output logic               int_req,
    output logic [ID_W-1:0]    int_id,
    input  logic               int_ack,
    input  logic               eret
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        SERV = 2'b10
    } state_t;

    state_t             state_q;
    logic [NUM_SRC-1:0] mask_q;
    logic [NUM_SRC-1:0] pend_q;

    logic               wr_mask;
    logic               wr_pend;
    logic               ack_hit;
    logic [NUM_SRC-1:0] clr_bits;
    logic [NUM_SRC-1:0] pend_d;
    logic [NUM_SRC-1:0] active;
    logic               any_active;
    logic [ID_W-1:0]    low_id;
    logic               id_still_active;

    logic unused_bits;
    assign unused_bits = ^{ADD_I[31:4], ADD_I[1:0], DAT_I[31:NUM_SRC]};

    // Bus decode, clear sources, next pending value and priority pick
    always_comb begin
        wr_mask    = WE && (ADD_I[3:2] == 2'b00);
        wr_pend    = WE && (ADD_I[3:2] == 2'b01);
        ack_hit    = (state_q == REQ) && int_ack;
        clr_bits   = '0;
        active     = pend_q & mask_q;
        any_active = |active;
        low_id     = '0;
        id_still_active = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            clr_bits[i] = (wr_pend && DAT_I[i]) || (ack_hit && (int_id == ID_W'(i)));
            if (int_id == ID_W'(i)) begin
                id_still_active = active[i];
            end
        end
        // descending scan so the lowest set index is the one left standing
        for (int unsigned i = NUM_SRC; i > 0; i--) begin
            if (active[i-1]) begin
                low_id = ID_W'(i - 1);
            end
        end
        // a set from the device line always beats a clear in the same cycle
        pend_d = irq_in | (pend_q & ~clr_bits);
    end

    // MASK and PEND registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask_q <= '0;
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
            if (wr_mask) begin
                mask_q <= DAT_I[NUM_SRC-1:0];
            end
        end
    end

    // Request/service FSM with registered int_req and int_id
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            int_id  <= '0;
            int_req <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_active) begin
                        int_id  <= low_id;
                        state_q <= REQ;
                        int_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (int_ack) begin
                        state_q <= SERV;
                        int_req <= 1'b0;
                    end else if (!id_still_active) begin
                        state_q <= IDLE;
                        int_req <= 1'b0;
                    end
                end
                SERV: begin
                    if (eret) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    int_req <= 1'b0;
                end
            endcase
        end
    end

    // Combinational bus read mux
    always_comb begin
        DAT_O = '0;
        case (ADD_I[3:2])
            2'b00: DAT_O[NUM_SRC-1:0] = mask_q;
            2'b01: DAT_O[NUM_SRC-1:0] = pend_q;
            2'b10: begin
                DAT_O[9:8]      = state_q;
                DAT_O[ID_W-1:0] = int_id;
            end
            default: DAT_O = '0;
        endcase
    end

endmodule
